vc_fifo: RTL and testbench

Parametrised multi-channel flit buffer for router input ports: NUM_VC independent circular queues in one block, each DEPTH entries deep and DATA_W bits wide. It replaces the single-queue input FIFO and adds per-VC status, a real full-at-DEPTH condition, an almost-full credit hint, occupancy outputs and sticky overflow/underflow error flags. Writes come from the upstream link and reads from the router's switch allocator, both on one clock.

---
 rtl/vc_fifo.sv | 151 +++++++++++++++
 tb/tb_vc_fifo.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/vc_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vc_fifo
// Description : Multi-channel flit buffer for a router input port. NUM_VC
//               independent circular queues, each DEPTH = 2**DEPTH_LOG2
//               entries of DATA_W bits, sharing one write port (upstream link)
//               and one read port (switch allocator) on a single clock.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   write        in   write request
//   write_vc     in   target VC of the write
//   item_in      in   write data
//   read         in   read (pop) request
//   read_vc      in   VC to read
//   item_out     out  head of the read_vc queue, 0 when empty or out of range
//   full         out  per-VC: count == DEPTH
//   empty        out  per-VC: count == 0
//   almost_full  out  per-VC: count >= DEPTH - AF_MARGIN
//   count        out  per-VC occupancy, VC v at [v*CNT_W +: CNT_W]
//   overflow     out  sticky: write attempted to a full VC
//   underflow    out  sticky: read attempted from an empty VC
//
// Revision    : 1.0 - initial release
// ============================================================================
module vc_fifo #(
    parameter int  DATA_W     = 32,
    parameter int  DEPTH_LOG2 = 2,
    parameter int  NUM_VC     = 2,
    parameter int  AF_MARGIN  = 1,
    localparam int VC_W       = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int CNT_W      = DEPTH_LOG2 + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      write,
    input  logic [VC_W-1:0]           write_vc,
    input  logic [DATA_W-1:0]         item_in,
    input  logic                      read,
    input  logic [VC_W-1:0]           read_vc,
    output logic [DATA_W-1:0]         item_out,
    output logic [NUM_VC-1:0]         full,
    output logic [NUM_VC-1:0]         empty,
    output logic [NUM_VC-1:0]         almost_full,
    output logic [NUM_VC*CNT_W-1:0]   count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int                c_depth    = 1 << DEPTH_LOG2;
    // A depth of one still needs a one-bit pointer; it simply never leaves 0.
    localparam int                c_ptr_w    = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
    localparam logic [CNT_W-1:0]  c_full_cnt = CNT_W'(c_depth);
    localparam logic [CNT_W-1:0]  c_af_thr   = CNT_W'(c_depth - AF_MARGIN);
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(c_depth - 1);
    localparam logic [VC_W:0]     c_num_vc   = (VC_W + 1)'(NUM_VC);

    logic                w_wr_vc_ok;
    logic                w_rd_vc_ok;
    logic                w_wr_tgt_full;
    logic                w_rd_tgt_empty;
    logic                w_wr_acc;
    logic                w_rd_acc;
    logic [NUM_VC-1:0]   w_full;
    logic [NUM_VC-1:0]   w_empty;
    logic [NUM_VC-1:0]   w_af;
    logic [DATA_W-1:0]   w_head [NUM_VC];
    logic                r_overflow;
    logic                r_underflow;

    // Requests naming a VC that does not exist are silently ignored.
    assign w_wr_vc_ok = ({1'b0, write_vc} < c_num_vc);
    assign w_rd_vc_ok = ({1'b0, read_vc}  < c_num_vc);

    always_comb begin
        w_wr_tgt_full  = 1'b0;
        w_rd_tgt_empty = 1'b0;
        if (w_wr_vc_ok) w_wr_tgt_full  = w_full[write_vc];
        if (w_rd_vc_ok) w_rd_tgt_empty = w_empty[read_vc];
    end

    // Status is taken from the pre-edge count, so on a full VC a same-cycle
    // read wins and the write is refused; on an empty VC the reverse.
    assign w_wr_acc = write && w_wr_vc_ok && !w_wr_tgt_full  && !reset;
    assign w_rd_acc = read  && w_rd_vc_ok && !w_rd_tgt_empty && !reset;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        logic [c_ptr_w-1:0] r_rp;
        logic [c_ptr_w-1:0] r_wp;
        logic [CNT_W-1:0]   r_cnt;
        logic [DATA_W-1:0]  r_mem [c_depth];
        logic               w_wr_hit;
        logic               w_rd_hit;

        assign w_wr_hit = w_wr_acc && (write_vc == VC_W'(v));
        assign w_rd_hit = w_rd_acc && (read_vc  == VC_W'(v));

        always_ff @(posedge clk) begin
            if (reset) begin
                r_rp  <= '0;
                r_wp  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_wr_hit) r_wp <= (r_wp == c_ptr_last) ? '0 : r_wp + c_ptr_w'(1);
                if (w_rd_hit) r_rp <= (r_rp == c_ptr_last) ? '0 : r_rp + c_ptr_w'(1);
                case ({w_wr_hit, w_rd_hit})
                    2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                    2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                    default: r_cnt <= r_cnt;
                endcase
            end
        end

        // Storage is deliberately not reset; stale entries are unreachable
        // once the pointers and count are cleared.
        always_ff @(posedge clk) begin
            if (w_wr_hit) r_mem[r_wp] <= item_in;
        end

        assign w_full[v]                   = (r_cnt == c_full_cnt);
        assign w_empty[v]                  = (r_cnt == '0);
        assign w_af[v]                     = (r_cnt >= c_af_thr);
        assign count[v*CNT_W +: CNT_W]     = r_cnt;
        assign w_head[v]                   = r_mem[r_rp];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (write && w_wr_vc_ok && w_wr_tgt_full)  r_overflow  <= 1'b1;
            if (read  && w_rd_vc_ok && w_rd_tgt_empty) r_underflow <= 1'b1;
        end
    end

    // No bypass: an empty queue shows 0 even if it is being written now.
    always_comb begin
        item_out = '0;
        if (w_rd_vc_ok && !w_rd_tgt_empty) item_out = w_head[read_vc];
    end

    assign full        = w_full;
    assign empty       = w_empty;
    assign almost_full = w_af;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_vc_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_vc_fifo
// Description : Self-checking bench for vc_fifo. Each VC is modelled as a
//               queue; directed sequences are followed by random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vc_fifo;

    localparam int c_dw    = 32;
    localparam int c_dl    = 2;
    localparam int c_nv    = 3;
    localparam int c_af    = 1;
    localparam int c_vw    = 2;
    localparam int c_cw    = 3;
    localparam int c_depth = 4;

    logic                   clk;
    logic                   reset;
    logic                   write;
    logic [c_vw-1:0]        write_vc;
    logic [c_dw-1:0]        item_in;
    logic                   read;
    logic [c_vw-1:0]        read_vc;
    logic [c_dw-1:0]        item_out;
    logic [c_nv-1:0]        full;
    logic [c_nv-1:0]        empty;
    logic [c_nv-1:0]        almost_full;
    logic [c_nv*c_cw-1:0]   count;
    logic                   overflow;
    logic                   underflow;

    vc_fifo #(
        .DATA_W     (c_dw),
        .DEPTH_LOG2 (c_dl),
        .NUM_VC     (c_nv),
        .AF_MARGIN  (c_af)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .write       (write),
        .write_vc    (write_vc),
        .item_in     (item_in),
        .read        (read),
        .read_vc     (read_vc),
        .item_out    (item_out),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [c_dw-1:0] mq [c_nv][$];
    bit              m_ovf;
    bit              m_udf;
    int              total;
    int              bad;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int v = 0; v < c_nv; v++) mq[v].delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    // One clock cycle: drive on the falling edge, check 1 ns later against the
    // model's current state, then advance the model across the rising edge.
    task automatic cycle(input bit w, input int wv, input logic [c_dw-1:0] d,
                         input bit r, input int rv, input bit rs);
        logic [c_nv*c_cw-1:0] e_cnt;
        logic [c_nv-1:0]      e_full, e_empty, e_af;
        logic [c_dw-1:0]      e_item;
        bit                   wacc, racc;
        @(negedge clk);
        write    = w;
        write_vc = c_vw'(wv);
        item_in  = d;
        read     = r;
        read_vc  = c_vw'(rv);
        reset    = rs;
        #1;
        for (int v = 0; v < c_nv; v++) begin
            e_cnt[v*c_cw +: c_cw] = c_cw'(mq[v].size());
            e_full[v]  = (mq[v].size() == c_depth);
            e_empty[v] = (mq[v].size() == 0);
            e_af[v]    = (mq[v].size() >= c_depth - c_af);
        end
        e_item = '0;
        if (rv < c_nv && mq[rv].size() > 0) e_item = mq[rv][0];
        chk("count",       64'(count),       64'(e_cnt));
        chk("full",        64'(full),        64'(e_full));
        chk("empty",       64'(empty),       64'(e_empty));
        chk("almost_full", 64'(almost_full), 64'(e_af));
        chk("item_out",    64'(item_out),    64'(e_item));
        chk("overflow",    64'(overflow),    64'(m_ovf));
        chk("underflow",   64'(underflow),   64'(m_udf));
        @(posedge clk);
        if (rs) begin
            model_clear();
        end else begin
            wacc = w && wv < c_nv && mq[wv].size() < c_depth;
            racc = r && rv < c_nv && mq[rv].size() > 0;
            if (w && wv < c_nv && mq[wv].size() == c_depth) m_ovf = 1'b1;
            if (r && rv < c_nv && mq[rv].size() == 0)       m_udf = 1'b1;
            if (racc) void'(mq[rv].pop_front());
            if (wacc) mq[wv].push_back(d);
        end
    endtask

    task automatic idle();
        cycle(0, 0, '0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cycle(0, 0, '0, 0, 0, 1);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        write    = 1'b0;
        write_vc = '0;
        item_in  = '0;
        read     = 1'b0;
        read_vc  = '0;
        repeat (2) @(posedge clk);
        model_clear();
        idle();

        // Fill VC1 past full, then drain it and read once more.
        for (int i = 1; i <= 4; i++) cycle(1, 1, c_dw'(32'h11 * i), 0, 1, 0);
        cycle(1, 1, 32'h55, 0, 1, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, '0, 1, 1, 0);
        idle();
        do_reset();

        // Wrap-around at occupancy 2 on VC0.
        cycle(1, 0, 32'h100, 0, 0, 0);
        cycle(1, 0, 32'h101, 0, 0, 0);
        for (int i = 2; i < 12; i++) cycle(1, 0, c_dw'(32'h100 + i), 1, 0, 0);
        cycle(0, 0, '0, 1, 0, 0);
        cycle(0, 0, '0, 1, 0, 0);
        idle();

        // Same-VC write+read at full, then at empty.
        for (int i = 0; i < 4; i++) cycle(1, 0, c_dw'(32'h200 + i), 0, 0, 0);
        cycle(1, 0, 32'h2FF, 1, 0, 0);
        idle();
        do_reset();
        cycle(1, 0, 32'h300, 1, 0, 0);
        idle();
        do_reset();

        // VC isolation: interleaved writes while VC1 drains.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) cycle(1, 0, c_dw'(32'hA0 + i), 1, 1, 0);
            else            cycle(1, 1, c_dw'(32'hB0 + i), 1, 1, 0);
        end
        for (int i = 0; i < 4; i++) cycle(0, 0, '0, 1, 0, 0);
        do_reset();

        // Reset together with a write while VC0 holds three entries.
        for (int i = 0; i < 3; i++) cycle(1, 0, c_dw'(32'h400 + i), 0, 0, 0);
        cycle(1, 0, 32'h4FF, 0, 0, 1);
        idle();

        // Out-of-range VC on both ports.
        cycle(1, 3, 32'hDEAD, 1, 3, 0);
        cycle(1, 3, 32'hBEEF, 1, 3, 0);
        cycle(0, 0, '0, 0, 3, 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 3) != 0, int'($urandom % 4), $urandom,
                  ($urandom % 2) != 0, int'($urandom % 4),
                  ($urandom % 200) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
